// File: rtl/mil_link_mux.sv
// mil_link_mux
//   Multiplexes several MIL transceiver channels onto one upstream word stream.
//   It also demultiplexes one downstream word stream back onto the transceivers.
//   Each channel buffers received words in a small FIFO. A round-robin arbiter
//   feeds a single output register, which can move one word per cycle.
//
// Ports
//   clk, rst              single rising-edge clock; asynchronous active-high reset
//   rx_valid/data/type    per-channel received words (no backpressure)
//   up_valid/ready/data/type/chan   merged upstream stream (valid/ready)
//   dn_valid/ready/data/type/chan   downstream stream to the transceivers
//   tx_valid/data/type    per-channel transmit strobe plus held word
//   tx_busy               per-channel transceiver-busy input
//   ovf, ovf_clr          sticky per-channel receive-overflow flags and their clear
//   bad_chan              pulses when a down word targets a nonexistent channel
module mil_link_mux #(
  parameter int CHANNELS   = 2,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS-1:0]        rx_valid,
  input  logic [CHANNELS*DATA_W-1:0] rx_data,
  input  logic [CHANNELS-1:0]        rx_type,
  output logic                       up_valid,
  input  logic                       up_ready,
  output logic [DATA_W-1:0]          up_data,
  output logic                       up_type,
  output logic [CH_W-1:0]            up_chan,
  input  logic                       dn_valid,
  output logic                       dn_ready,
  input  logic [DATA_W-1:0]          dn_data,
  input  logic                       dn_type,
  input  logic [CH_W-1:0]            dn_chan,
  output logic [CHANNELS-1:0]        tx_valid,
  output logic [CHANNELS*DATA_W-1:0] tx_data,
  output logic [CHANNELS-1:0]        tx_type,
  input  logic [CHANNELS-1:0]        tx_busy,
  output logic [CHANNELS-1:0]        ovf,
  input  logic                       ovf_clr,
  output logic                       bad_chan
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CH_W:0] NUM_CH = (CH_W+1)'(CHANNELS);

  logic [DATA_W:0]     headWord [CHANNELS];
  logic [CHANNELS-1:0] nonEmpty;
  logic [CHANNELS-1:0] popSel;

  logic [CH_W-1:0] rrReg;
  logic [CH_W-1:0] grantIdx;
  logic            grantValid;
  logic [CH_W:0]   scanIdx;
  logic [CH_W:0]   rrPlus;
  logic            loadEn;

  logic chanOk;
  logic chanBusy;
  logic dnFire;

  // The output register may load when it is empty or being drained this cycle.
  assign loadEn = !up_valid || up_ready;

  // ---------------------------------------------------------------- receive FIFOs
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic [DATA_W:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             pushOk;
    logic             ovfBit;

    assign full   = (count == (PTR_W+1)'(FIFO_DEPTH));
    // A full FIFO still accepts a write when its head leaves in the same cycle.
    assign pushOk = rx_valid[gi] && (!full || popSel[gi]);

    assign nonEmpty[gi] = (count != '0);
    assign headWord[gi] = mem[rdPtr];
    assign ovf[gi]      = ovfBit;

    // The storage array has no reset; only the pointers define FIFO contents.
    always_ff @(posedge clk) begin
      if (pushOk) begin
        mem[wrPtr] <= {rx_type[gi], rx_data[gi*DATA_W +: DATA_W]};
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wrPtr  <= '0;
        rdPtr  <= '0;
        count  <= '0;
        ovfBit <= 1'b0;
      end else begin
        if (pushOk) begin
          wrPtr <= wrPtr + 1'b1;
        end
        if (popSel[gi]) begin
          rdPtr <= rdPtr + 1'b1;
        end
        if (pushOk && !popSel[gi]) begin
          count <= count + 1'b1;
        end else if (!pushOk && popSel[gi]) begin
          count <= count - 1'b1;
        end
        // A new drop takes priority over a clear in the same cycle.
        if (rx_valid[gi] && !pushOk) begin
          ovfBit <= 1'b1;
        end else if (ovf_clr) begin
          ovfBit <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- arbiter
  // Scan from the highest offset down so the lowest offset from rrReg wins.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    scanIdx    = '0;
    for (int off = CHANNELS - 1; off >= 0; off--) begin
      scanIdx = {1'b0, rrReg} + (CH_W+1)'(off);
      if (scanIdx >= NUM_CH) begin
        scanIdx = scanIdx - NUM_CH;
      end
      if (nonEmpty[scanIdx[CH_W-1:0]]) begin
        grantValid = 1'b1;
        grantIdx   = scanIdx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    rrPlus = {1'b0, grantIdx} + 1'b1;
    if (rrPlus >= NUM_CH) begin
      rrPlus = '0;
    end
  end

  always_comb begin
    popSel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      popSel[i] = loadEn && grantValid && (grantIdx == CH_W'(i));
    end
  end

  // ---------------------------------------------------------------- output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrReg    <= '0;
      up_valid <= 1'b0;
      up_data  <= '0;
      up_type  <= 1'b0;
      up_chan  <= '0;
    end else if (loadEn) begin
      up_valid <= grantValid;
      if (grantValid) begin
        up_data <= headWord[grantIdx][DATA_W-1:0];
        up_type <= headWord[grantIdx][DATA_W];
        up_chan <= grantIdx;
        rrReg   <= rrPlus[CH_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------- downstream
  // dn_chan can encode channels that do not exist. Those words are always
  // accepted and then discarded.
  always_comb begin
    chanOk   = 1'b0;
    chanBusy = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (dn_chan == CH_W'(i)) begin
        chanOk   = 1'b1;
        chanBusy = tx_busy[i] || tx_valid[i];
      end
    end
  end

  assign dn_ready = !rst && (!chanOk || !chanBusy);
  assign dnFire   = dn_valid && dn_ready;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_tx
    logic hit;
    assign hit = dnFire && chanOk && (dn_chan == CH_W'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tx_valid[gi]                 <= 1'b0;
        tx_data[gi*DATA_W +: DATA_W] <= '0;
        tx_type[gi]                  <= 1'b0;
      end else begin
        tx_valid[gi] <= hit;
        if (hit) begin
          tx_data[gi*DATA_W +: DATA_W] <= dn_data;
          tx_type[gi]                  <= dn_type;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_chan <= 1'b0;
    end else begin
      bad_chan <= dnFire && !chanOk;
    end
  end

endmodule

// File: tb/tb_mil_link_mux.sv
// Bench for mil_link_mux: a two-channel instance covers the main function and
// a three-channel instance covers nonexistent-channel handling.
module tb_mil_link_mux;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  rx_valid;
  logic [31:0] rx_data;
  logic [1:0]  rx_type;
  logic        up_valid, up_ready, up_type;
  logic [15:0] up_data;
  logic [0:0]  up_chan;
  logic        dn_valid, dn_ready, dn_type;
  logic [15:0] dn_data;
  logic [0:0]  dn_chan;
  logic [1:0]  tx_valid, tx_type, tx_busy, ovf;
  logic [31:0] tx_data;
  logic        ovf_clr, bad_chan;

  // three-channel instance signals
  logic        up_valid3, up_type3, dn_valid3, dn_ready3, bad_chan3;
  logic [15:0] up_data3;
  logic [1:0]  up_chan3, dn_chan3;
  logic [2:0]  tx_valid3, tx_type3, ovf3;
  logic [47:0] tx_data3;

  int checks = 0;
  int errors = 0;
  logic [17:0] expQ[$];

  mil_link_mux #(.CHANNELS(2), .DATA_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_type(rx_type),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .up_type(up_type), .up_chan(up_chan),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
    .dn_type(dn_type), .dn_chan(dn_chan),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_type(tx_type),
    .tx_busy(tx_busy), .ovf(ovf), .ovf_clr(ovf_clr), .bad_chan(bad_chan)
  );

  mil_link_mux #(.CHANNELS(3), .DATA_W(16), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .rst(rst),
    .rx_valid(3'b000), .rx_data(48'h0), .rx_type(3'b000),
    .up_valid(up_valid3), .up_ready(1'b1), .up_data(up_data3),
    .up_type(up_type3), .up_chan(up_chan3),
    .dn_valid(dn_valid3), .dn_ready(dn_ready3), .dn_data(16'h3333),
    .dn_type(1'b1), .dn_chan(dn_chan3),
    .tx_valid(tx_valid3), .tx_data(tx_data3), .tx_type(tx_type3),
    .tx_busy(3'b000), .ovf(ovf3), .ovf_clr(1'b0), .bad_chan(bad_chan3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: every accepted upstream word is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && up_valid && up_ready) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL up_unexpected: got chan %0d type %0d data 0x%0h, expected no word",
                 up_chan, up_type, up_data);
      end else begin
        logic [17:0] e;
        e = expQ.pop_front();
        if ({up_chan, up_type, up_data} !== e) begin
          errors++;
          $display("FAIL up_word: got chan %0d type %0d data 0x%0h, expected chan %0d type %0d data 0x%0h",
                   up_chan, up_type, up_data, e[17], e[16], e[15:0]);
        end else begin
          $display("ok   up_word: chan %0d type %0d data 0x%0h", up_chan, up_type, up_data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    rx_valid = '0; rx_data = '0; rx_type = '0; up_ready = 1'b0;
    dn_valid = 1'b0; dn_data = '0; dn_type = 1'b0; dn_chan = '0;
    tx_busy = '0; ovf_clr = 1'b0; dn_valid3 = 1'b0; dn_chan3 = '0;
    expQ.delete();
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    doReset();
    rst = 1'b1;
    #1;
    check("reset_up_valid", 32'(up_valid), 32'd0);
    check("reset_dn_ready", 32'(dn_ready), 32'd0);
    check("reset_tx_ovf_bad", {tx_valid, ovf, bad_chan}, 32'd0);

    // Single word: strobed at edge 0 (first edge after reset), visible after edge 1
    doReset();
    up_ready = 1'b1;
    rx_valid = 2'b01; rx_data = {16'h0, 16'h1234}; rx_type = 2'b01;
    expQ.push_back({1'b0, 1'b1, 16'h1234});
    tick();
    rx_valid = '0;
    check("single_not_yet", 32'(up_valid), 32'd0);
    tick();
    check("single_valid", 32'(up_valid), 32'd1);
    tick();
    check("single_one_cycle", 32'(up_valid), 32'd0);

    // Fairness: both channels strobe 3 words together
    doReset();
    up_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expQ.push_back({1'b0, 1'b0, 16'hA000 + 16'(k)});
      expQ.push_back({1'b1, 1'b1, 16'hB000 + 16'(k)});
    end
    for (int k = 0; k < 3; k++) begin
      rx_valid = 2'b11; rx_type = 2'b10;
      rx_data = {16'hB000 + 16'(k), 16'hA000 + 16'(k)};
      tick();
    end
    rx_valid = '0;
    repeat (8) tick();
    check("fair_drained", 32'(expQ.size()), 32'd0);

    // Overflow: 6 words on ch1 while stalled. One word sits in the output
    // register and four in the FIFO, so the 6th word is dropped.
    doReset();
    up_ready = 1'b0;
    for (int k = 1; k <= 5; k++) expQ.push_back({1'b1, 1'(k), 16'hC000 + 16'(k)});
    for (int k = 1; k <= 6; k++) begin
      rx_valid = 2'b10; rx_type = {1'(k), 1'b0};
      rx_data = {16'hC000 + 16'(k), 16'h0};
      tick();
    end
    rx_valid = '0;
    check("ovf_set", 32'(ovf), 32'b10);
    check("stall_valid", 32'(up_valid), 32'd1);
    tick(); tick();
    check("stall_hold_data", 32'(up_data), 32'hC001);
    check("stall_hold_chan", 32'(up_chan), 32'd1);
    rx_valid = 2'b10; rx_data = {16'hC007, 16'h0}; ovf_clr = 1'b1;
    tick();
    rx_valid = '0;
    check("ovf_set_beats_clr", 32'(ovf), 32'b10);
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'b00);
    up_ready = 1'b1;
    repeat (10) tick();
    check("ovf_drained", 32'(expQ.size()), 32'd0);

    // Transmit path, plus the nonexistent-channel case on the 3-channel instance
    doReset();
    dn_chan = 1'b1; dn_data = 16'hBEEF; dn_type = 1'b1; dn_valid = 1'b1;
    dn_chan3 = 2'd3; dn_valid3 = 1'b1;
    #1;
    check("tx_ready_idle", 32'(dn_ready), 32'd1);
    check("bad_ready", 32'(dn_ready3), 32'd1);
    tick();
    dn_valid = 1'b0; dn_valid3 = 1'b0;
    #1;
    check("tx_pulse", 32'(tx_valid), 32'b10);
    check("tx_data1", 32'(tx_data[31:16]), 32'hBEEF);
    check("tx_type", 32'(tx_type), 32'b10);
    check("bad_pulse", 32'(bad_chan3), 32'd1);
    check("bad_no_tx", 32'(tx_valid3), 32'd0);
    tick();
    check("tx_one_cycle", 32'(tx_valid), 32'b00);
    check("tx_data_held", 32'(tx_data[31:16]), 32'hBEEF);
    check("bad_one_cycle", 32'(bad_chan3), 32'd0);
    tx_busy = 2'b10; dn_valid = 1'b1; dn_data = 16'h5555; dn_type = 1'b0;
    #1;
    check("tx_busy_ready", 32'(dn_ready), 32'd0);
    tick();
    check("tx_busy_no_pulse", 32'(tx_valid), 32'b00);
    tx_busy = 2'b00;
    #1;
    check("tx_busy_cleared", 32'(dn_ready), 32'd1);
    tick();
    dn_valid = 1'b0;
    check("tx_second_pulse", 32'(tx_valid), 32'b10);
    check("tx_second_data", 32'(tx_data[31:16]), 32'h5555);

    // Reset mid-stream: output register full, 2 words buffered, tx pulse live
    doReset();
    up_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rx_valid = 2'b01; rx_data = {16'h0, 16'hE000 + 16'(k)};
      tick();
    end
    rx_valid = '0;
    dn_chan = 1'b0; dn_data = 16'h7777; dn_valid = 1'b1;
    tick();
    dn_valid = 1'b0;
    check("pre_rst_valid", 32'(up_valid), 32'd1);
    check("pre_rst_tx", 32'(tx_valid), 32'b01);
    rst = 1'b1;
    #1;
    check("rst_async_up", {up_valid, up_type, up_chan, up_data}, 32'd0);
    check("rst_async_tx", {tx_valid, tx_type, ovf, bad_chan}, 32'd0);
    check("rst_async_txdata", tx_data, 32'd0);
    check("rst_dn_ready", 32'(dn_ready), 32'd0);
    tick(); tick();
    rst = 1'b0; up_ready = 1'b1;
    rx_valid = 2'b10; rx_type = 2'b10; rx_data = {16'hD00D, 16'h0};
    expQ.push_back({1'b1, 1'b1, 16'hD00D});
    tick();
    rx_valid = '0;
    repeat (8) tick();
    check("rst_no_stale", 32'(expQ.size()), 32'd0);
    check("rst_no_tx", 32'(tx_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
